// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy hit tracker and its box-compare helper.
package enemy_pkg;

  // Enemy life cycle: waiting for spawn, vulnerable, blinking after a hit, death animation
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIVE = 2'd1,
    FLASH = 2'd2,
    DYING = 2'd3
  } enemy_state_t;

  // Visible screen extent; bullets may sit partly outside it
  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  // One extra bit over screen coordinates so box expansion never wraps
  typedef logic [10:0] coord_ext_t;

  // Zero-extends a 10-bit screen coordinate into the compare width
  function automatic coord_ext_t extendCoord(input logic [9:0] coord);
    return {1'b0, coord};
  endfunction

endpackage

// File: rtl/enemy_hit_tracker_if.sv
// Frame-rate signal bundle between the game logic and one enemy hit tracker.
interface enemy_hit_tracker_if;

  logic       frame_tick;
  logic       enemy_spawn;
  logic       bullet_active;
  logic [9:0] BulletX;
  logic [9:0] BulletY;
  logic [9:0] EnemyX;
  logic [9:0] EnemyY;
  logic [9:0] EnemyWidth;
  logic [9:0] EnemyHeight;
  logic       collision;
  logic       enemy_alive;
  logic       enemy_flash;
  logic       enemy_dying;
  logic [3:0] health;
  logic [15:0] score;

  // Game logic side: supplies positions and frame timing, reads enemy status
  modport master (
    output frame_tick, enemy_spawn, bullet_active,
    output BulletX, BulletY, EnemyX, EnemyY, EnemyWidth, EnemyHeight,
    input  collision, enemy_alive, enemy_flash, enemy_dying, health, score
  );

  // Tracker side
  modport slave (
    input  frame_tick, enemy_spawn, bullet_active,
    input  BulletX, BulletY, EnemyX, EnemyY, EnemyWidth, EnemyHeight,
    output collision, enemy_alive, enemy_flash, enemy_dying, health, score
  );

endinterface

// File: rtl/enemy_hit_tracker_hit_box_compare.sv
// Combinational point-vs-box overlap test with the box grown by a radius on every
// side, so a round projectile of that radius touching the box counts as a hit.
// Written generically so a player-vs-enemy-bullet check can reuse it.
module hit_box_compare
  import enemy_pkg::*;
#(
  parameter int BULLET_R = 3
) (
  input  coord_ext_t bulletX,
  input  coord_ext_t bulletY,
  input  coord_ext_t boxX,
  input  coord_ext_t boxY,
  input  coord_ext_t boxWidth,
  input  coord_ext_t boxHeight,
  output logic       inBox
);

  localparam coord_ext_t RADIUS = coord_ext_t'(BULLET_R);

  coord_ext_t xHigh;
  coord_ext_t yHigh;
  logic       xOk;
  logic       yOk;

  // Low edges are tested by adding the radius to the bullet side instead of
  // subtracting from the box, which keeps everything unsigned near coordinate 0
  always_comb begin
    xHigh = boxX + boxWidth - 11'd1 + RADIUS;
    yHigh = boxY + boxHeight - 11'd1 + RADIUS;
    xOk   = (bulletX + RADIUS >= boxX) && (bulletX <= xHigh);
    yOk   = (bulletY + RADIUS >= boxY) && (bulletY <= yHigh);
    inBox = xOk && yOk;
  end

endmodule

// File: rtl/enemy_hit_tracker.sv
// Per-enemy bullet collision, health, hit-flash, death animation and kill score.
// Everything advances only on the single-cycle frame tick, so the bullet stage
// sees a collision level that is stable for a whole frame.
module enemy_hit_tracker
  import enemy_pkg::*;
#(
  parameter int HP_INIT      = 3,
  parameter int FLASH_FRAMES = 8,
  parameter int DEATH_FRAMES = 30,
  parameter int BULLET_R     = 3,
  parameter int KILL_POINTS  = 100
) (
  input logic Clk,
  input logic Reset,
  enemy_hit_tracker_if.slave bus
);

  localparam logic [3:0]  HP_LOAD     = 4'(HP_INIT);
  localparam logic [5:0]  FLASH_LOAD  = 6'(FLASH_FRAMES);
  localparam logic [5:0]  DEATH_LOAD  = 6'(DEATH_FRAMES);
  localparam logic [16:0] KILL_ADD    = 17'(KILL_POINTS);

  enemy_state_t state;
  enemy_state_t stateNext;
  logic [5:0]   frameCount;
  logic [5:0]   frameCountNext;
  logic [3:0]   healthReg;
  logic [3:0]   healthNext;
  logic [15:0]  scoreReg;
  logic [15:0]  scoreNext;
  logic         collisionReg;
  logic         collisionNext;

  logic         inBox;
  logic         rawHit;
  logic [16:0]  scoreSum;
  logic [15:0]  scoreSat;

  hit_box_compare #(
    .BULLET_R (BULLET_R)
  ) boxCompare (
    .bulletX   (extendCoord(bus.BulletX)),
    .bulletY   (extendCoord(bus.BulletY)),
    .boxX      (extendCoord(bus.EnemyX)),
    .boxY      (extendCoord(bus.EnemyY)),
    .boxWidth  (extendCoord(bus.EnemyWidth)),
    .boxHeight (extendCoord(bus.EnemyHeight)),
    .inBox     (inBox)
  );

  // Overlap only matters while the bullet is actually in flight; the kill score
  // is precomputed with a carry bit so it can clamp at the 16-bit ceiling
  always_comb begin
    rawHit   = inBox && bus.bullet_active;
    scoreSum = {1'b0, scoreReg} + KILL_ADD;
    scoreSat = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
  end

  // Frame-tick next-state logic; between ticks every register simply holds
  always_comb begin
    stateNext      = state;
    frameCountNext = frameCount;
    healthNext     = healthReg;
    scoreNext      = scoreReg;
    collisionNext  = collisionReg;

    if (bus.frame_tick) begin
      collisionNext = rawHit && ((state == ALIVE) || (state == FLASH));

      unique case (state)
        IDLE: begin
          if (bus.enemy_spawn) begin
            stateNext  = ALIVE;
            healthNext = HP_LOAD;
          end
        end

        ALIVE: begin
          if (rawHit) begin
            if (healthReg <= 4'd1) begin
              stateNext      = DYING;
              healthNext     = 4'd0;
              frameCountNext = DEATH_LOAD;
              scoreNext      = scoreSat;
            end else begin
              stateNext      = FLASH;
              healthNext     = healthReg - 4'd1;
              frameCountNext = FLASH_LOAD;
            end
          end
        end

        FLASH: begin
          frameCountNext = frameCount - 6'd1;
          if (frameCount == 6'd1) begin
            stateNext = ALIVE;
          end
        end

        DYING: begin
          frameCountNext = frameCount - 6'd1;
          if (frameCount == 6'd1) begin
            stateNext  = IDLE;
            healthNext = 4'd0;
          end
        end

        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // State, counters, score and the collision level; reset abandons any flash or death
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      frameCount   <= 6'd0;
      healthReg    <= 4'd0;
      scoreReg     <= 16'd0;
      collisionReg <= 1'b0;
    end else begin
      state        <= stateNext;
      frameCount   <= frameCountNext;
      healthReg    <= healthNext;
      scoreReg     <= scoreNext;
      collisionReg <= collisionNext;
    end
  end

  // Status flags decode straight from the registered state
  always_comb begin
    bus.collision   = collisionReg;
    bus.enemy_alive = (state == ALIVE) || (state == FLASH);
    bus.enemy_flash = (state == FLASH);
    bus.enemy_dying = (state == DYING);
    bus.health      = healthReg;
    bus.score       = scoreReg;
  end

endmodule
